// File: rtl/cmd_pkg.sv
// ----------------------------------------------------------------------------
// cmd_pkg
//   Shared types and widths for the command dispatcher.
//   - OPC_W / OPR_W : opcode and operand field widths of a 16-bit command
//   - CMD_W         : full command width
//   - disp_state_t  : dispatch FSM states
// ----------------------------------------------------------------------------
package cmd_pkg;

    localparam int OPC_W = 4;
    localparam int OPR_W = 12;
    localparam int CMD_W = OPC_W + OPR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        SEND    = 2'd2,
        WAIT_TX = 2'd3
    } disp_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// ----------------------------------------------------------------------------
// cmd_fifo
//   Synchronous FIFO, DEPTH x W, with a combinational head output.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (flushes pointers)
//     push, din  : write request and data; a push while full is only taken
//                  if a pop happens in the same cycle
//     pop        : remove the head entry (ignored when empty)
//     dout       : current head entry (combinational)
//     full/empty : occupancy flags
//     cnt        : current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] cnt
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot the push needs, so full+pop still accepts.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is not reset: a flush only needs the pointers and count cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cmd_dispatch.sv
// ----------------------------------------------------------------------------
// cmd_dispatch
//   Buffers 16-bit commands from the UART receiver, issues each one to the
//   executor as opcode/operand, and answers each with an ACK or NAK byte
//   to the UART transmitter.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     cmd_rdy, cmd        : command from receiver (level, held until cleared)
//     clr_cmd_rdy         : tells the receiver its command was taken
//     op_vld, opcode,
//     operand, op_done    : executor handshake
//     trmt, tx_data,
//     tx_done             : transmitter handshake
//     overflow            : sticky, a command was dropped because FIFO was full
//     fifo_cnt            : FIFO occupancy
//     dbg_state           : current dispatch FSM state
//
//   Handshakes: cmd_rdy/clr_cmd_rdy -- every presented command is consumed
//   in the cycle it is seen (queued, or dropped with overflow set when full).
//   op_vld rises with opcode/operand stable and stays high until op_done is
//   seen; op_done is only honoured while op_vld is high. trmt is a one-cycle
//   start pulse; tx_data carries the response from the end of that cycle
//   until the next response; tx_done is only honoured after trmt while the
//   FSM waits for it.
// ----------------------------------------------------------------------------
module cmd_dispatch
    import cmd_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] VALID_MASK = 16'h00FF,
    parameter logic [7:0]  ACK_BYTE   = 8'hA5,
    parameter logic [7:0]  NAK_BYTE   = 8'hEE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_rdy,
    input  logic [CMD_W-1:0]       cmd,
    output logic                   clr_cmd_rdy,
    output logic                   op_vld,
    output logic [OPC_W-1:0]       opcode,
    output logic [OPR_W-1:0]       operand,
    input  logic                   op_done,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output disp_state_t            dbg_state
);

    disp_state_t      state;
    disp_state_t      next_state;
    logic [CMD_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             head_legal;
    logic [7:0]       resp;

    // Ingest: the receiver is always released in the same cycle.
    assign clr_cmd_rdy = cmd_rdy;
    assign pop         = (state == IDLE) && !fifo_empty;
    assign push        = cmd_rdy && (!fifo_full || pop);
    assign head_legal  = VALID_MASK[head[CMD_W-1 -: OPC_W]];

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (cmd),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        next_state = state;
        op_vld     = 1'b0;
        trmt       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = head_legal ? BUSY : SEND;
                end
            end
            BUSY: begin
                op_vld = 1'b1;
                if (op_done) next_state = SEND;
            end
            SEND: begin
                trmt       = 1'b1;
                next_state = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign dbg_state = state;

    // Datapath: command fields, pending response, transmit byte, overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode   <= '0;
            operand  <= '0;
            resp     <= '0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                opcode  <= head[CMD_W-1 -: OPC_W];
                operand <= head[OPR_W-1:0];
                if (!head_legal) resp <= NAK_BYTE;
            end
            if ((state == BUSY) && op_done) begin
                resp <= ACK_BYTE;
            end
            if (state == SEND) begin
                tx_data <= resp;
            end
            if (cmd_rdy && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
module tb_cmd_dispatch;
    import cmd_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_rdy = 1'b0;
    logic [15:0] cmd = '0;
    logic        op_done = 1'b0;
    logic        tx_done = 1'b0;
    logic        clr_cmd_rdy;
    logic        op_vld;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        overflow;
    logic [2:0]  fifo_cnt;
    disp_state_t dbg_state;

    always #5 clk = ~clk;

    cmd_dispatch #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .clr_cmd_rdy (clr_cmd_rdy),
        .op_vld      (op_vld),
        .opcode      (opcode),
        .operand     (operand),
        .op_done     (op_done),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .overflow    (overflow),
        .fifo_cnt    (fifo_cnt),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];     // commands accepted, oldest first (incl. the one executing)
    logic [15:0] burst_q[$];   // stimulus for the next burst
    bit          model_ovf = 0;

    // Opcodes 0..7 are legal, 8..15 are not.
    function automatic logic legal(input logic [15:0] c);
        return (c[15:12] < 4'd8);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Present burst_q on consecutive cycles with the executor stalled. With an
    // empty, idle dispatcher the first command goes into execution and the
    // next DEPTH are queued; anything beyond that is dropped.
    task automatic burst();
        int n;
        int acc;
        n = burst_q.size();
        for (int i = 0; i < n; i++) begin
            cmd     = burst_q[i];
            cmd_rdy = 1'b1;
            if (i <= DEPTH) exp_q.push_back(burst_q[i]);
            else            model_ovf = 1;
            sample();
            check("clr_cmd_rdy_burst", 32'(clr_cmd_rdy), 32'd1);
            tick();
        end
        cmd_rdy = 1'b0;
        sample();
        tick();
        sample();
        acc = (n < DEPTH + 1) ? n : DEPTH + 1;
        check("burst_fifo_cnt", 32'(fifo_cnt), 32'(acc - 1));
        check("burst_overflow", 32'(overflow), 32'(model_ovf));
        check("clr_cmd_rdy_idle", 32'(clr_cmd_rdy), 32'd0);
        tick();
    endtask

    // Act as executor and transmitter with random response delays until every
    // expected command has been answered.
    task automatic drain(input int max_cycles);
        int          cyc = 0;
        int          od_wait = -1;
        int          td_wait = -1;
        bit          op_seen = 0;
        bit          chk_tx = 0;
        bit          tx_pend = 0;
        bit          nxt_od;
        bit          nxt_td;
        logic [7:0]  exp_byte = '0;
        logic [15:0] cur;
        while (!(exp_q.size() == 0 && !tx_pend && !chk_tx) && cyc < max_cycles) begin
            sample();
            nxt_od = 0;
            nxt_td = 0;
            if (chk_tx) begin
                check("tx_data", 32'(tx_data), 32'(exp_byte));
                check("trmt_one_cycle", 32'(trmt), 32'd0);
                chk_tx = 0;
            end
            if (op_vld) begin
                if (!op_seen) begin
                    op_seen = 1;
                    if (exp_q.size() == 0) begin
                        check("op_vld_unexpected", 32'(op_vld), 32'd0);
                    end else begin
                        cur = exp_q[0];
                        check("op_vld_legal", 32'(op_vld), 32'(legal(cur)));
                        check("opcode", 32'(opcode), 32'(cur[15:12]));
                        check("operand", 32'(operand), 32'(cur[11:0]));
                    end
                    od_wait = $urandom_range(0, 3);
                end
                if (od_wait == 0) begin
                    nxt_od  = 1;
                    od_wait = -1;
                end else if (od_wait > 0) begin
                    od_wait--;
                end
            end
            if (trmt) begin
                if (exp_q.size() == 0) begin
                    check("trmt_unexpected", 32'(trmt), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("opcode_at_resp", 32'(opcode), 32'(cur[15:12]));
                    check("operand_at_resp", 32'(operand), 32'(cur[11:0]));
                    check("executed_iff_legal", 32'(op_seen), 32'(legal(cur)));
                    exp_byte = legal(cur) ? 8'hA5 : 8'hEE;
                    chk_tx   = 1;
                end
                op_seen = 0;
                tx_pend = 1;
                td_wait = $urandom_range(0, 3);
            end else if (tx_pend) begin
                if (td_wait == 0) begin
                    nxt_td  = 1;
                    tx_pend = 0;
                end else begin
                    td_wait--;
                end
            end
            tick();
            op_done = nxt_od;
            tx_done = nxt_td;
            cyc++;
        end
        check("drain_timeout", 32'(cyc >= max_cycles), 32'd0);
        tick();
        op_done = 1'b0;
        tx_done = 1'b0;
        sample();
        check("drain_idle", 32'(dbg_state), 32'(IDLE));
        check("drain_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("drain_overflow", 32'(overflow), 32'(model_ovf));
        tick();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        // Reset state
        sample();
        sample();
        check("rst_op_vld", 32'(op_vld), 32'd0);
        check("rst_trmt", 32'(trmt), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_operand", 32'(operand), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        rst_n = 1'b1;
        tick();

        // 1: legal command, latency to op_vld is two cycles
        exp_q.push_back(16'h3123);
        cmd     = 16'h3123;
        cmd_rdy = 1'b1;
        sample();
        check("t1_clr_same_cycle", 32'(clr_cmd_rdy), 32'd1);
        check("t1_op_vld_c0", 32'(op_vld), 32'd0);
        tick();
        cmd_rdy = 1'b0;
        sample();
        check("t1_clr_low", 32'(clr_cmd_rdy), 32'd0);
        check("t1_op_vld_c1", 32'(op_vld), 32'd0);
        tick();
        sample();
        check("t1_op_vld_c2", 32'(op_vld), 32'd1);
        check("t1_opcode", 32'(opcode), 32'h3);
        check("t1_operand", 32'(operand), 32'h123);
        tick();
        drain(200);

        // 2: illegal opcode gets a NAK without execution
        exp_q.push_back(16'hF000);
        cmd     = 16'hF000;
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        drain(200);

        // 6: stray op_done in IDLE and stray tx_done in BUSY are ignored
        op_done = 1'b1;
        sample();
        tick();
        op_done = 1'b0;
        sample();
        check("t6_idle_after_op_done", 32'(dbg_state), 32'(IDLE));
        check("t6_no_trmt", 32'(trmt), 32'd0);
        tick();
        exp_q.push_back(16'h5ABC);
        cmd     = 16'h5ABC;
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        tick();
        sample();
        check("t6_busy", 32'(op_vld), 32'd1);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        sample();
        check("t6_still_busy", 32'(dbg_state), 32'(BUSY));
        check("t6_op_vld_held", 32'(op_vld), 32'd1);
        tick();
        drain(200);

        // 4: full FIFO, push coincides with the IDLE pop
        burst_q = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005};
        burst();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        sample();
        check("t4_trmt", 32'(trmt), 32'd1);
        tick();
        tx_done = 1'b1;
        sample();
        check("t4_tx_data", 32'(tx_data), 32'hA5);
        tick();
        tx_done = 1'b0;
        cmd     = 16'h6066;
        cmd_rdy = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(16'h6066);
        sample();
        check("t4_idle_pop", 32'(dbg_state), 32'(IDLE));
        check("t4_cnt_full", 32'(fifo_cnt), 32'd4);
        tick();
        cmd_rdy = 1'b0;
        sample();
        check("t4_cnt_unchanged", 32'(fifo_cnt), 32'd4);
        check("t4_no_overflow", 32'(overflow), 32'd0);
        check("t4_next_opcode", 32'(opcode), 32'h2);
        tick();
        drain(300);

        // 3: six commands with the executor stalled, sixth dropped
        burst_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
        burst();
        drain(300);

        // 5: reset during BUSY with three queued
        burst_q = '{16'h7111, 16'h7222, 16'h7333, 16'h7444};
        burst();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_op_vld", 32'(op_vld), 32'd0);
        check("t5_opcode", 32'(opcode), 32'd0);
        check("t5_operand", 32'(operand), 32'd0);
        check("t5_tx_data", 32'(tx_data), 32'd0);
        check("t5_overflow", 32'(overflow), 32'd0);
        check("t5_fifo_cnt", 32'(fifo_cnt), 32'd0);
        check("t5_state", 32'(dbg_state), 32'(IDLE));
        exp_q.delete();
        model_ovf = 0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample();
            check("t5_no_trmt", 32'(trmt), 32'd0);
            check("t5_no_op_vld", 32'(op_vld), 32'd0);
            tick();
        end

        // Random bursts: first command legal so the stall lands in BUSY
        for (int b = 0; b < 10; b++) begin
            int n;
            n = $urandom_range(1, 7);
            burst_q.delete();
            burst_q.push_back({4'($urandom_range(0, 7)), 12'($urandom)});
            for (int i = 1; i < n; i++) burst_q.push_back(16'($urandom));
            burst();
            drain(400);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
